// File: rtl/disp_median3x3_pkg.sv
// Shared definitions for the 3x3 disparity median filter.
//   DWIDTH    : default disparity sample width
//   CNT_W     : width of the column/line counters and of the width input
//   MAX_WIDTH : widest supported image line
//   PIPE_LAT  : clken-qualified edges from accepting a column to its result
package disp_median3x3_pkg;

  localparam int DWIDTH    = 11;
  localparam int CNT_W     = 11;
  localparam int MAX_WIDTH = 1936;
  localparam int PIPE_LAT  = 3;

  typedef logic [CNT_W-1:0] cnt_t;

  // Line counter saturates here instead of wrapping back into lines 0/1.
  localparam cnt_t LIN_MAX = '1;

  // Per-column side information that travels with the data through the pipe.
  typedef struct packed {
    logic border;  // window centre sits on column 0 or width-1
    logic vld;     // result may be flagged valid
  } tag_t;

endpackage

// File: rtl/disp_median3x3_if.sv
// Streaming bus of the 3x3 disparity median filter.
//   clken             : sample strobe, one column of taps per high cycle
//   enable            : output gate copied into valid
//   sof               : start of frame, marks column 0 of line 0
//   width             : image width in pixels
//   row0/1/2_in       : current line, one-line delayed, two-line delayed taps
//   dout, valid       : filtered disparity and its qualifier
// master = pixel source, slave = filter.
interface disp_median3x3_if #(
  parameter int DWIDTH = disp_median3x3_pkg::DWIDTH
);
  import disp_median3x3_pkg::*;

  logic              clken;
  logic              enable;
  logic              sof;
  cnt_t              width;
  logic [DWIDTH-1:0] row0_in;
  logic [DWIDTH-1:0] row1_in;
  logic [DWIDTH-1:0] row2_in;
  logic [DWIDTH-1:0] dout;
  logic              valid;

  modport master (
    output clken, enable, sof, width, row0_in, row1_in, row2_in,
    input  dout, valid
  );

  modport slave (
    input  clken, enable, sof, width, row0_in, row1_in, row2_in,
    output dout, valid
  );

endinterface

// File: rtl/disp_median3x3_sort3.sv
// disp_sort3: purely combinational three-input sorter.
//   a, b, c : unsigned inputs
//   lo      : smallest, mid : median, hi : largest
// Ties may be broken either way; the output values are the same.
module disp_sort3 #(
  parameter int W = 11
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] lo,
  output logic [W-1:0] mid,
  output logic [W-1:0] hi
);

  logic [W-1:0] ab_lo;
  logic [W-1:0] ab_hi;

  always_comb begin
    ab_lo = (a < b) ? a : b;
    ab_hi = (a < b) ? b : a;
    lo    = (c < ab_lo) ? c : ab_lo;
    hi    = (c > ab_hi) ? c : ab_hi;
    // c either falls below, above or between the ordered pair {ab_lo, ab_hi}.
    if (c < ab_lo) begin
      mid = ab_lo;
    end else if (c > ab_hi) begin
      mid = ab_hi;
    end else begin
      mid = c;
    end
  end

endmodule

// File: rtl/disp_median3x3.sv
// disp_median3x3: 3x3 median filter for a disparity stream whose three
// vertical taps come from external line buffers.
//   clk : rising-edge clock
//   rst : asynchronous, active-low reset
//   bus : disp_median3x3_if.slave (clken/enable/sof/width/row*_in in,
//         dout/valid out)
// Pipeline, advanced only on clken:
//   A: sort the incoming column, shift into a 3-deep sorted-column register
//   B: max of lows, median of mids, min of highs across the three columns
//   C: median of those three = true 3x3 median; border centres bypass it
// The window centre is row1 of the middle column (c-1). Result for the
// column accepted on clken edge k appears after the second following edge.
module disp_median3x3 #(
  parameter int DWIDTH = disp_median3x3_pkg::DWIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  disp_median3x3_if.slave       bus
);
  import disp_median3x3_pkg::*;

  typedef logic [DWIDTH-1:0] pix_t;

  // ---------------------------------------------------------------- counters
  cnt_t col_reg;
  cnt_t lin_reg;
  logic framed_reg;

  cnt_t col_cur;
  cnt_t lin_cur;
  cnt_t col_next;
  cnt_t lin_next;
  logic framed_next;
  logic last_col;
  tag_t tag_in;

  // sof overrides the running position for the column that carries it.
  always_comb begin
    col_cur     = bus.sof ? '0 : col_reg;
    lin_cur     = bus.sof ? '0 : lin_reg;
    last_col    = (col_cur == (bus.width - cnt_t'(1)));
    col_next    = last_col ? '0 : (col_cur + cnt_t'(1));
    lin_next    = (last_col && (lin_cur != LIN_MAX)) ? (lin_cur + cnt_t'(1)) : lin_cur;
    framed_next = framed_reg | bus.sof;
    tag_in      = '0;
    // The centre is column c-1: c==1 puts it on column 0, c==0 on width-1.
    tag_in.border = (col_cur == cnt_t'(0)) || (col_cur == cnt_t'(1));
    // Lines 0 and 1 lack a full vertical neighbourhood; nothing is valid
    // until a frame has actually started.
    tag_in.vld    = framed_next && (lin_cur >= cnt_t'(2)) && bus.enable;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_reg    <= '0;
      lin_reg    <= '0;
      framed_reg <= 1'b0;
    end else if (bus.clken) begin
      col_reg    <= col_next;
      lin_reg    <= lin_next;
      framed_reg <= framed_next;
    end
  end

  // ----------------------------------------------------------------- stage A
  pix_t new_lo;
  pix_t new_mid;
  pix_t new_hi;

  disp_sort3 #(.W(DWIDTH)) u_sort_col (
    .a   (bus.row0_in),
    .b   (bus.row1_in),
    .c   (bus.row2_in),
    .lo  (new_lo),
    .mid (new_mid),
    .hi  (new_hi)
  );

  // Index 0 holds column c, 1 holds c-1, 2 holds c-2.
  pix_t lo_reg  [3];
  pix_t mid_reg [3];
  pix_t hi_reg  [3];
  pix_t raw1_reg [2];
  tag_t tag_a_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        lo_reg[i]  <= '0;
        mid_reg[i] <= '0;
        hi_reg[i]  <= '0;
      end
      raw1_reg[0] <= '0;
      raw1_reg[1] <= '0;
      tag_a_reg   <= '0;
    end else if (bus.clken) begin
      lo_reg[0]  <= new_lo;
      mid_reg[0] <= new_mid;
      hi_reg[0]  <= new_hi;
      for (int i = 1; i < 3; i++) begin
        lo_reg[i]  <= lo_reg[i-1];
        mid_reg[i] <= mid_reg[i-1];
        hi_reg[i]  <= hi_reg[i-1];
      end
      raw1_reg[0] <= bus.row1_in;
      raw1_reg[1] <= raw1_reg[0];
      tag_a_reg   <= tag_in;
    end
  end

  // ----------------------------------------------------------------- stage B
  pix_t mx_b;
  pix_t mn_b;
  pix_t md_b;
  pix_t mid_unused_lo;
  pix_t mid_unused_hi;

  always_comb begin
    mx_b = lo_reg[0];
    if (lo_reg[1] > mx_b) mx_b = lo_reg[1];
    if (lo_reg[2] > mx_b) mx_b = lo_reg[2];
    mn_b = hi_reg[0];
    if (hi_reg[1] < mn_b) mn_b = hi_reg[1];
    if (hi_reg[2] < mn_b) mn_b = hi_reg[2];
  end

  disp_sort3 #(.W(DWIDTH)) u_sort_mid (
    .a   (mid_reg[0]),
    .b   (mid_reg[1]),
    .c   (mid_reg[2]),
    .lo  (mid_unused_lo),
    .mid (md_b),
    .hi  (mid_unused_hi)
  );

  pix_t mx_reg;
  pix_t md_reg;
  pix_t mn_reg;
  pix_t center_reg;
  tag_t tag_b_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mx_reg     <= '0;
      md_reg     <= '0;
      mn_reg     <= '0;
      center_reg <= '0;
      tag_b_reg  <= '0;
    end else if (bus.clken) begin
      mx_reg     <= mx_b;
      md_reg     <= md_b;
      mn_reg     <= mn_b;
      center_reg <= raw1_reg[1];
      tag_b_reg  <= tag_a_reg;
    end
  end

  // ----------------------------------------------------------------- stage C
  pix_t med_c;
  pix_t med_unused_lo;
  pix_t med_unused_hi;

  disp_sort3 #(.W(DWIDTH)) u_sort_med (
    .a   (mx_reg),
    .b   (md_reg),
    .c   (mn_reg),
    .lo  (med_unused_lo),
    .mid (med_c),
    .hi  (med_unused_hi)
  );

  pix_t dout_reg;
  logic valid_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (bus.clken) begin
      dout_reg  <= tag_b_reg.border ? center_reg : med_c;
      valid_reg <= tag_b_reg.vld;
    end
  end

  assign bus.dout  = dout_reg;
  assign bus.valid = valid_reg;

endmodule

// File: tb/tb_disp_median3x3.sv
// Self-checking bench for disp_median3x3: stimulus pushes expected results
// into a queue, an independent monitor pops and compares on clken edges.
`timescale 1ns/1ps
module tb_disp_median3x3;
  import disp_median3x3_pkg::*;

  localparam int DW = 11;
  typedef logic [DW-1:0] pix_t;

  typedef struct {
    pix_t dout;
    logic vld;
    bit   hd_en;
    pix_t hdout;
    bit   hv_en;
    logic hvld;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  disp_median3x3_if #(.DWIDTH(DW)) bus();

  disp_median3x3 #(.DWIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_txn    = 0;
  int   duty     = 100;

  // Reference model state: the two previous columns and the frame position.
  pix_t m_prev1 [3];
  pix_t m_prev2 [3];
  int   m_col;
  int   m_lin;
  bit   m_framed;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_prev1[k] = '0;
      m_prev2[k] = '0;
    end
    m_col    = 0;
    m_lin    = 0;
    m_framed = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.clken = 1'b0;
    bus.sof   = 1'b0;
  endtask

  // Drive one column and queue its expected result (full 9-value sort).
  task automatic send(input pix_t r0, input pix_t r1, input pix_t r2,
                      input bit s, input bit en,
                      input bit hd, input pix_t hdv, input bit hv, input logic hvv);
    pix_t w [9];
    pix_t t;
    exp_t e;
    int   c, l, j;
    @(negedge clk);
    while (duty < 100 && $urandom_range(0, 99) >= duty) begin
      bus.clken = 1'b0;
      bus.sof   = 1'b0;
      @(negedge clk);
    end
    bus.clken   = 1'b1;
    bus.sof     = s;
    bus.enable  = en;
    bus.row0_in = r0;
    bus.row1_in = r1;
    bus.row2_in = r2;
    c = s ? 0 : m_col;
    l = s ? 0 : m_lin;
    if (s) m_framed = 1'b1;
    for (int k = 0; k < 3; k++) begin
      w[k]     = m_prev2[k];
      w[3 + k] = m_prev1[k];
    end
    w[6] = r0;
    w[7] = r1;
    w[8] = r2;
    for (int i = 1; i < 9; i++) begin
      t = w[i];
      j = i;
      while (j > 0 && w[j-1] > t) begin
        w[j] = w[j-1];
        j--;
      end
      w[j] = t;
    end
    e.dout  = (c == 0 || c == 1) ? m_prev1[1] : w[4];
    e.vld   = m_framed && (l >= 2) && en;
    e.hd_en = hd;
    e.hdout = hdv;
    e.hv_en = hv;
    e.hvld  = hvv;
    exp_q.push_back(e);
    m_prev2 = m_prev1;
    m_prev1 = '{r0, r1, r2};
    if (c == int'(bus.width) - 1) begin
      c = 0;
      if (l < 2047) l++;
    end else begin
      c++;
    end
    m_col = c;
    m_lin = l;
  endtask

  task automatic send_rand(input bit s, input bit hv);
    send(pix_t'($urandom_range(0, 2047)), pix_t'($urandom_range(0, 2047)),
         pix_t'($urandom_range(0, 2047)), s, 1'b1, 1'b0, '0, hv, 1'b0);
  endtask

  // Asynchronous reset between clock edges, then hold it for a few cycles.
  task automatic async_reset();
    #3;
    rst = 1'b0;
    #1;
    check("rst_async_dout", int'(bus.dout), 0);
    check("rst_async_valid", int'(bus.valid), 0);
    exp_q.delete();
    model_reset();
    bus.clken = 1'b0;
    bus.sof   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hold_dout", int'(bus.dout), 0);
    check("rst_hold_valid", int'(bus.valid), 0);
    rst = 1'b1;
  endtask

  // Monitor: every clken edge retires one pipeline slot.
  initial begin : monitor
    exp_t e;
    logic en_s;
    logic rst_s;
    forever begin
      @(posedge clk);
      en_s  = bus.clken;
      rst_s = rst;
      #1;
      if (rst_s && en_s && exp_q.size() >= PIPE_LAT) begin
        e = exp_q.pop_front();
        n_txn++;
        $display("txn %0d: dout=%0d valid=%0d (want %0d/%0d)", n_txn,
                 bus.dout, bus.valid, e.dout, e.vld);
        check("dout", int'(bus.dout), int'(e.dout));
        check("valid", int'(bus.valid), int'(e.vld));
        if (e.hd_en) check("hand_dout", int'(bus.dout), int'(e.hdout));
        if (e.hv_en) check("hand_valid", int'(bus.valid), int'(e.hvld));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    pix_t r0, r1, r2, hdv;
    bit   en, hd, hv;
    logic hvv;

    bus.clken   = 1'b0;
    bus.enable  = 1'b0;
    bus.sof     = 1'b0;
    bus.width   = cnt_t'(8);
    bus.row0_in = '0;
    bus.row1_in = '0;
    bus.row2_in = '0;
    model_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("reset_dout", int'(bus.dout), 0);
    check("reset_valid", int'(bus.valid), 0);
    repeat (2) @(negedge clk);
    rst  = 1'b1;
    duty = 70;

    // Columns before any sof never produce valid.
    for (int n = 0; n < 3; n++) send_rand(1'b0, 1'b1);

    // Frame A, width 8: directed content line by line.
    for (int l = 0; l < 7; l++) begin
      for (int c = 0; c < 8; c++) begin
        if (l == 6 && c == 4) break;
        r0 = pix_t'($urandom_range(0, 2047));
        r1 = pix_t'($urandom_range(0, 2047));
        r2 = pix_t'($urandom_range(0, 2047));
        en = 1'b1; hd = 1'b0; hdv = '0; hv = 1'b0; hvv = 1'b0;
        if (l < 2) begin
          hv = 1'b1;
        end else if (l == 2) begin
          r0 = 5; r1 = 5; r2 = 5;
          if (c >= 1) begin hd = 1'b1; hdv = 5; hv = 1'b1; hvv = 1'b1; end
        end else if (l == 3) begin
          r0 = 10; r1 = 10; r2 = 10;
          case (c)
            1: begin r0 = 1; r1 = 8; r2 = 4; end
            2: begin r0 = 9; r1 = 3; r2 = 6; end
            3: begin r0 = 2; r1 = 7; r2 = 5; hd = 1'b1; hdv = 5; hv = 1'b1; hvv = 1'b1; end
            5: r1 = 2047;
            6: begin hd = 1'b1; hdv = 10; hv = 1'b1; hvv = 1'b1; end
            default: ;
          endcase
        end else if (l == 4) begin
          en = 1'b0; r0 = 0; r2 = 0;
          r1 = (c == 0 || c == 7) ? pix_t'(100) : pix_t'(0);
          hv = 1'b1;
          if (c == 1) begin hd = 1'b1; hdv = 100; end
        end else begin
          r0 = 10; r1 = 10; r2 = 10;
          if (l == 5 && c == 0) begin hd = 1'b1; hdv = 100; hv = 1'b1; hvv = 1'b1; end
        end
        send(r0, r1, r2, (l == 0 && c == 0), en, hd, hdv, hv, hvv);
      end
    end
    async_reset();

    // After reset nothing is valid until a new sof, even past line 2.
    for (int n = 0; n < 20; n++) send_rand(1'b0, 1'b1);

    // Frame B: filtering resumes from line 2.
    for (int l = 0; l < 4; l++) begin
      for (int c = 0; c < 8; c++) begin
        if (l == 2) begin
          send(7, 7, 7, 1'b0, 1'b1, (c >= 1), 7, (c >= 1), 1'b1);
        end else begin
          send_rand((l == 0 && c == 0), (l < 2));
        end
      end
    end

    // Full-width frame with 30% clken duty and random data.
    idle();
    bus.width = cnt_t'(MAX_WIDTH);
    duty = 30;
    for (int n = 0; n < 3 * MAX_WIDTH + 40; n++) send_rand((n == 0), 1'b0);
    duty = 100;
    send(0, 0, 0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    send(0, 0, 0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    repeat (5) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/disp_median3x3.md
DISP_MEDIAN3X3 -- requirements
Module: disp_median3x3

Interface
REQ-001 Parameter DWIDTH, default 11, disparity sample width.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 clken  input  1  sample strobe; one new column of taps per cycle when high; all state holds when low.
REQ-005 enable  input  1  output gate; copied into valid for emitted pixels.
REQ-006 sof  input  1  start of frame, sampled with clken; marks column 0 of line 0.
REQ-007 width  input  11  image width in pixels, 3..1936, static within a frame.
REQ-008 row0_in  input  DWIDTH  current-line pixel (undelayed).
REQ-009 row1_in  input  DWIDTH  pixel delayed one line by the upstream line buffer.
REQ-010 row2_in  input  DWIDTH  pixel delayed two lines by the second line buffer.
REQ-011 dout  output  DWIDTH  filtered disparity.
REQ-012 valid  output  1  dout qualifier.

Function
REQ-013 Column counter col: 0 on sof&clken, else +1 per clken, wraps width-1 -> 0.
REQ-014 Line counter lin: 0 on sof&clken, +1 on each col wrap, saturates at 2047.
REQ-015 Each clken, the new column {row0_in,row1_in,row2_in} SHALL be sorted into lo/mid/hi and shifted into a 3-deep sorted-column register (columns c, c-1, c-2).
REQ-016 Stage B (next clken): mx = max of three lo, md = med of three mid, mn = min of three hi.
REQ-017 Stage C (next clken): dout = median(mx, md, mn); equals the true 3x3 median.
REQ-018 Window center = row1 at column c-1; raw center value SHALL be carried alongside the pipeline.
REQ-019 Border: if the center column is 0 or width-1 (col==1 or col==0 at input), dout = raw center unfiltered.
REQ-020 Lines with lin<2 at input SHALL produce valid=0; later lines SHALL produce valid=enable.
REQ-021 Latency: sample accepted on clken k yields dout/valid on the 3rd following clken edge; exactly 3 clken-qualified edges, stall cycles excluded.
REQ-022 With clken low, dout, valid and all pipeline registers hold value.
REQ-023 Comparisons unsigned; ties resolved arbitrarily, result value unaffected.
REQ-024 sof mid-frame SHALL restart col/lin at 0 immediately; in-flight pipeline entries finish with their own tags.

Reset
REQ-025 While rst low: dout=0, valid=0, col=0, lin=0, all pipeline data and tags 0.
REQ-026 Reset asserted mid-operation SHALL clear state immediately, independent of clk; first pixel after release requires sof.
REQ-027 Before the first sof after reset, valid SHALL stay 0.

Structure
REQ-028 Shared package: DWIDTH, counter width 11, MAX_WIDTH=1936, PIPE_LAT=3.
REQ-029 One combinational sub-module disp_sort3 (3 inputs -> lo/mid/hi), instantiated for new-column sort and reused for med-of-three.
REQ-030 Three sequential stages only; no SRAM; line buffering stays upstream.

Verification
REQ-031 width=8, lines 0-1 any data, line 2 all taps=5 -> valid=0 for lines 0-1, dout=5 valid=1 from line 2, 3 clken after each input.
REQ-032 Line 3 interior window rows {1,9,2},{8,3,7},{4,6,5} -> dout=5; single impulse 2047 in flat field 10 -> dout=10.
REQ-033 Border: col 0/col 7 centers with row1=100, neighbours 0 -> dout=100 unfiltered.
REQ-034 Random clken duty 30%, random data, width=1936 -> output sequence matches golden model, no sample lost or duplicated.
REQ-035 enable=0 on line 4 -> valid=0 there, dout still updates; enable=1 restores valid.
REQ-036 rst pulse mid-line then sof -> outputs 0/valid 0 immediately; correct filtering resumes from line 2 of new frame.
